// File: rtl/vram_arbiter.sv
// vram_arbiter
// Owns the single-port synchronous video RAM (four planes of 2**AW bytes:
// 0 blue, 1 red, 2 greenx, 3 green) and time-multiplexes it between the video
// fetch and CPU accesses. Video has strict priority. A started CPU access is
// never pre-empted.
//
// Ports
//   clock, reset        system clock (rising edge), async active-high reset
//   ce                  pixel clock enable; each pulse requests one video fetch
//   vb, va              video plane / address, sampled when the fetch starts
//   vd                  fetched video byte (holds until the next fetch)
//   cpu_req/we/bank/a/d CPU request; sampled only while the FSM is idle
//   cpu_q               CPU read data, valid from the cpu_ack cycle
//   cpu_ack             one-clock completion pulse
//   wait_n              active-low CPU wait (combinational)
//   ram_a/ram_d/ram_we  registered RAM address {bank, addr}, data, write enable
//   ram_q               RAM read data, one clock after the address
//   dbg_state           current FSM state, for observation only
//
// CPU handshake: cpu_req is a level held until cpu_ack. wait_n is low while
// cpu_req is high and cpu_ack is not. cpu_ack is high for exactly one clock;
// if cpu_req is still high in that cycle it is taken as a new access.
module vram_arbiter #(
    parameter int AW = 13,
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic [1:0]    vb,
    input  logic [AW-1:0] va,
    output logic [DW-1:0] vd,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_bank,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_d,
    output logic [DW-1:0] cpu_q,
    output logic          cpu_ack,
    output logic          wait_n,
    output logic [AW+1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_VRD  = 3'd1,
        S_VLAT = 3'd2,
        S_CRD  = 3'd3,
        S_CLAT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          vpend_q, vpend_d;
    logic [DW-1:0] vd_q, vd_d;
    logic [DW-1:0] cpu_rd_q, cpu_rd_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          cpu_wr_q, cpu_wr_d;   // current CPU access is a write
    logic [AW+1:0] ram_a_q, ram_a_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_we_q, ram_we_d;
    logic          vreq;

    // A ce that arrives while the RAM is busy is remembered in vpend so the
    // fetch is only delayed, never lost.
    assign vreq = ce | vpend_q;

    always_comb begin
        state_d   = state_q;
        vpend_d   = vpend_q;
        vd_d      = vd_q;
        cpu_rd_d  = cpu_rd_q;
        cpu_ack_d = 1'b0;
        cpu_wr_d  = cpu_wr_q;
        ram_a_d   = ram_a_q;
        ram_d_d   = ram_d_q;
        ram_we_d  = ram_we_q;

        if (ce && (state_q != S_IDLE)) begin
            vpend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (vreq) begin
                    ram_a_d  = {vb, va};
                    ram_we_d = 1'b0;
                    vpend_d  = 1'b0;
                    state_d  = S_VRD;
                end else if (cpu_req) begin
                    ram_a_d  = {cpu_bank, cpu_a};
                    ram_d_d  = cpu_d;
                    ram_we_d = cpu_we;
                    cpu_wr_d = cpu_we;
                    state_d  = S_CRD;
                end
            end
            S_VRD: begin
                state_d = S_VLAT;
            end
            S_VLAT: begin
                vd_d    = ram_q;
                state_d = S_IDLE;
            end
            S_CRD: begin
                // Write enable was high for the single CRD cycle only.
                ram_we_d = 1'b0;
                state_d  = S_CLAT;
            end
            S_CLAT: begin
                cpu_ack_d = 1'b1;
                if (!cpu_wr_q) begin
                    cpu_rd_d = ram_q;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            vpend_q   <= 1'b0;
            vd_q      <= '0;
            cpu_rd_q  <= '0;
            cpu_ack_q <= 1'b0;
            cpu_wr_q  <= 1'b0;
            ram_a_q   <= '0;
            ram_d_q   <= '0;
            ram_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            vpend_q   <= vpend_d;
            vd_q      <= vd_d;
            cpu_rd_q  <= cpu_rd_d;
            cpu_ack_q <= cpu_ack_d;
            cpu_wr_q  <= cpu_wr_d;
            ram_a_q   <= ram_a_d;
            ram_d_q   <= ram_d_d;
            ram_we_q  <= ram_we_d;
        end
    end

    assign vd        = vd_q;
    assign cpu_q     = cpu_rd_q;
    assign cpu_ack   = cpu_ack_q;
    assign wait_n    = !(cpu_req && !cpu_ack_q);
    assign ram_a     = ram_a_q;
    assign ram_d     = ram_d_q;
    assign ram_we    = ram_we_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter. The RAM is modelled as a synchronous byte array;
// a separate reference copy of the expected RAM contents (ref_mem) gives the
// expected video and CPU read data from the access rules alone.
module tb_vram_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;

    logic          clock;
    logic          reset;
    logic          ce;
    logic [1:0]    vb;
    logic [AW-1:0] va;
    logic [DW-1:0] vd;
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_bank;
    logic [AW-1:0] cpu_a;
    logic [DW-1:0] cpu_d;
    logic [DW-1:0] cpu_q;
    logic          cpu_ack;
    logic          wait_n;
    logic [AW+1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;

    logic [DW-1:0] mem     [0:(1<<(AW+2))-1];
    logic [DW-1:0] ref_mem [0:(1<<(AW+2))-1];
    logic [DW-1:0] exp_q[$];

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset), .ce(ce), .vb(vb), .va(va), .vd(vd),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_a(cpu_a),
        .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack), .wait_n(wait_n),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_q(ram_q),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // synchronous single-port RAM, one clock read latency
    always @(posedge clock) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    always @(negedge clock) begin
        if (ram_we) we_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // one video fetch with no CPU traffic, checked edge by edge
    task automatic video_fetch(input logic [1:0] b, input logic [AW-1:0] a,
                               input logic [DW-1:0] prev);
        logic [DW-1:0] exp_vd;
        exp_vd = ref_mem[{b, a}];
        ce = 1'b1; vb = b; va = a;
        step();
        ce = 1'b0;
        check("vid_ram_a", ram_a, {b, a});
        check("vid_ram_we", ram_we, 0);
        step();
        check("vid_vd_early", vd, prev);
        step();
        check("vid_vd", vd, exp_vd);
        repeat (5) step();
    endtask

    initial begin
        logic [DW-1:0] vd_exp;
        logic [AW+1:0] addr;
        logic          we;
        logic [1:0]    bk;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        int            we_base;

        for (int i = 0; i < (1 << (AW + 2)); i++) begin
            mem[i]     = DW'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[15'h4123] = 8'hA5; ref_mem[15'h4123] = 8'hA5;
        mem[15'h0005] = 8'h77; ref_mem[15'h0005] = 8'h77;

        reset = 1'b1; ce = 1'b0; vb = '0; va = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_bank = '0; cpu_a = '0; cpu_d = '0;

        // reset values
        #1;
        check("rst_ram_a", ram_a, 0);
        check("rst_ram_d", ram_d, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_vd", vd, 0);
        check("rst_cpu_q", cpu_q, 0);
        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_wait_n", wait_n, 1);
        step(); step();
        reset = 1'b0;
        step();

        // video fetches every 8 clocks, no RAM writes expected
        we_base = we_cnt;
        video_fetch(2'd2, 13'h0123, 8'h00);
        video_fetch(2'd2, 13'h0123, 8'hA5);
        video_fetch(2'd2, 13'h0123, 8'hA5);
        check("vid_no_we", we_cnt - we_base, 0);

        // CPU write, no ce
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = 2'd1; cpu_a = 13'h1FFF; cpu_d = 8'h3C;
        ref_mem[15'h3FFF] = 8'h3C;
        #1;
        check("wr_wait_lo", wait_n, 0);
        step();
        check("wr_ram_a", ram_a, 15'h3FFF);
        check("wr_ram_we1", ram_we, 1);
        check("wr_ram_d", ram_d, 8'h3C);
        check("wr_ack0", cpu_ack, 0);
        step();
        check("wr_ram_we0", ram_we, 0);
        check("wr_ack1", cpu_ack, 0);
        check("wr_wait_lo2", wait_n, 0);
        step();
        check("wr_ack", cpu_ack, 1);
        check("wr_wait_hi", wait_n, 1);
        cpu_req = 1'b0;
        step();
        check("wr_ack_pulse", cpu_ack, 0);
        check("wr_mem", mem[15'h3FFF], 8'h3C);
        repeat (4) step();

        // collision: ce and CPU read in the same idle cycle
        bk = 2'($urandom_range(0, 3)); ad = AW'($urandom);
        vd_exp = ref_mem[{bk, ad}];
        ce = 1'b1; vb = bk; va = ad;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = 2'd0; cpu_a = 13'd5;
        exp_q.push_back(ref_mem[15'd5]);
        step();
        ce = 1'b0;
        check("col_vid_first", ram_a, {bk, ad});
        step(); step();
        check("col_vd", vd, vd_exp);
        check("col_ack_early", cpu_ack, 0);
        step();
        check("col_cpu_a", ram_a, 15'd5);
        step();
        check("col_ack_early2", cpu_ack, 0);
        step();
        check("col_ack", cpu_ack, 1);
        check("col_cpu_q", cpu_q, exp_q.pop_front());
        cpu_req = 1'b0;
        repeat (4) step();

        // ce arriving while a CPU access is in flight, 64 times
        for (int it = 0; it < 64; it++) begin
            we = 1'($urandom_range(0, 1));
            bk = 2'($urandom_range(0, 3)); ad = AW'($urandom); dt = DW'($urandom);
            cpu_req = 1'b1; cpu_we = we; cpu_bank = bk; cpu_a = ad; cpu_d = dt;
            if (we) ref_mem[{bk, ad}] = dt;
            else exp_q.push_back(ref_mem[{bk, ad}]);
            step();
            addr = {2'($urandom_range(0, 3)), AW'($urandom)};
            if ((it % 8) == 0) addr = {bk, ad};   // sometimes fetch what the CPU touched
            vd_exp = ref_mem[addr];
            ce = 1'b1; vb = addr[AW+1:AW]; va = addr[AW-1:0];
            step();
            ce = 1'b0;
            step();
            check("mid_ack", cpu_ack, 1);
            if (!we) check("mid_cpu_q", cpu_q, exp_q.pop_front());
            else check("mid_mem", mem[{bk, ad}], dt);
            cpu_req = 1'b0;
            repeat (6) step();
            check("mid_vd", vd, vd_exp);
        end

        // back-to-back CPU reads with cpu_req held through ack
        bk = 2'd3; ad = AW'($urandom);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_bank = bk; cpu_a = ad;
        exp_q.push_back(ref_mem[{bk, ad}]);
        step(); step(); step();
        check("b2b_ack1", cpu_ack, 1);
        check("b2b_q1", cpu_q, exp_q.pop_front());
        bk = 2'd2; ad = AW'($urandom);
        cpu_bank = bk; cpu_a = ad;
        exp_q.push_back(ref_mem[{bk, ad}]);
        step();
        check("b2b_a2", ram_a, {bk, ad});
        check("b2b_ack_gap", cpu_ack, 0);
        step();
        check("b2b_ack_gap2", cpu_ack, 0);
        step();
        check("b2b_ack2", cpu_ack, 1);
        check("b2b_q2", cpu_q, exp_q.pop_front());
        cpu_req = 1'b0;
        repeat (4) step();

        // reset in the middle of a CPU write
        addr = {2'($urandom_range(0, 3)), AW'($urandom)};
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_bank = addr[AW+1:AW]; cpu_a = addr[AW-1:0];
        cpu_d = ~ref_mem[addr];
        step();
        check("rw_we_before", ram_we, 1);
        #2 reset = 1'b1;
        #1;
        check("rw_we_abort", ram_we, 0);
        cpu_req = 1'b0;
        step();
        check("rw_no_ack", cpu_ack, 0);
        step();
        check("rw_no_ack2", cpu_ack, 0);
        check("rw_mem", mem[addr], ref_mem[addr]);
        reset = 1'b0;
        step();
        check("rw_vd_rst", vd, 0);
        video_fetch(2'd2, 13'h0123, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Upstream neighbour of the video generator. Owns the single-port synchronous video RAM: four 8 KB planes (0 blue, 1 red, 2 greenx, 3 green).
- Time-multiplexes the RAM between the video fetch (bank/address driven by the video generator, data returned on vd) and CPU read/write cycles.
- Video has strict priority. The CPU is held with wait_n until its access completes.

Parameters:
- AW, 13, per-plane address width
- DW, 8, data width

Ports:
- clock  in  1  system clock; all sequential logic on rising edge
- reset  in  1  asynchronous, active-high reset
- ce  in  1  pixel clock enable, same pulse that advances the video counters
- vb  in  2  video plane select
- va  in  AW  video plane address
- vd  out  DW  fetched video byte
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; sampled with the request
- cpu_bank  in  2  CPU plane select
- cpu_a  in  AW  CPU plane address
- cpu_d  in  DW  CPU write data
- cpu_q  out  DW  CPU read data, valid from the cpu_ack cycle
- cpu_ack  out  1  one-clock completion pulse
- wait_n  out  1  active-low CPU wait
- ram_a  out  AW+2  RAM address {bank, addr}, registered
- ram_d  out  DW  RAM write data, registered
- ram_we  out  1  RAM write enable, registered
- ram_q  in  DW  RAM read data; one-clock synchronous read latency

Behaviour:
- Reset (asynchronous): state IDLE, vpend=0, vd=0, cpu_q=0, cpu_ack=0, ram_a=0, ram_d=0, ram_we=0.
- wait_n is combinational: wait_n = !(cpu_req && !cpu_ack), so wait_n=1 during reset when cpu_req=0.
- Environment guarantee: ce pulses at least 8 clocks apart. Not checked.
- vreq = ce | vpend.
- vpend:
  - Set on any edge with ce=1 while the FSM cannot start the video fetch that cycle (state not IDLE).
  - Cleared when the video fetch starts.
- FSM states: IDLE, VRD, VLAT, CRD, CLAT.
- IDLE:
  - If vreq: ram_a <= {vb, va}, ram_we <= 0, go to VRD. Video wins over a simultaneous cpu_req.
  - Else if cpu_req: ram_a <= {cpu_bank, cpu_a}, ram_d <= cpu_d, ram_we <= cpu_we, go to CRD.
  - Else stay in IDLE.
- VRD: RAM samples the address. Go to VLAT.
- VLAT: vd <= ram_q, go to IDLE.
- vd latency: vd holds new data 3 edges after a ce sampled in IDLE, or 3 edges after the FSM reaches IDLE for a pended ce. Worst case from ce is 5 edges, which is before the next ce (at or after 8 clocks). vd holds its value otherwise.
- CRD: RAM performs the access. ram_we <= 0, so a write is exactly one clock wide. Go to CLAT.
- CLAT:
  - cpu_ack <= 1 for one clock.
  - On a read, cpu_q <= ram_q; on a write, cpu_q is unchanged.
  - Go to IDLE.
- cpu_ack is 0 in all other cycles.
- If cpu_req is still high in the IDLE cycle after ack, it is a new access. The CPU must drop cpu_req in the ack cycle to avoid a repeat.
- A CPU access is never pre-empted once started. Worst-case CPU latency is 3 video clocks plus 3 CPU clocks.
- cpu_* inputs are sampled only in IDLE; changes during CRD/CLAT are ignored.
- cpu_bank=3 and vb=3 are normal planes; there is no bank masking.
- ram_a wraps naturally inside the AW+2 space; no address arithmetic.
- Reset mid-operation:
  - Any in-flight write is aborted (ram_we=0 immediately).
  - No cpu_ack is issued.
  - vd keeps its reset value until the next fetch.

Test Plan:
- Reset with cpu_req=0 -> all registered outputs 0, wait_n=1. Release reset, ce every 8 clocks, vb=2, va=0x0123, RAM[0x4123]=0xA5 -> ram_a=0x4123 one edge after ce, vd=0xA5 3 edges after ce, ram_we never 1.
- CPU write, no ce: cpu_req=1, cpu_we=1, cpu_bank=1, cpu_a=0x1FFF, cpu_d=0x3C -> ram_a=0x3FFF with ram_we=1 for exactly one clock; cpu_ack pulses 2 edges later; wait_n low until the ack cycle; RAM[0x3FFF]=0x3C.
- Collision: ce and cpu read request (bank 0, addr 5, RAM=0x77) in the same IDLE cycle -> video fetch first (VRD, VLAT), then CRD/CLAT; cpu_q=0x77, ack 6 edges after request; vd correct before next ce.
- ce during a CPU access (ce one edge after the CPU access starts) -> vpend set, video fetch starts in the IDLE after CLAT, vd valid before the following ce, no lost fetch over 64 consecutive ce pulses.
- Back-to-back CPU reads with cpu_req held through ack -> second access starts in the IDLE after ack, second cpu_ack, no overlap with video.
- Assert reset during CRD of a write -> ram_we drops asynchronously, no cpu_ack. After release, FSM in IDLE and the next ce fetch behaves as in the first scenario.
